timing_adapter_arb_32: RTL

- Two-source, packet-level round-robin arbiter that shares the 37-bit streaming input of the 8-deep timing adapter FIFO between two requesters.
- Locks the grant for a whole packet (SOP to EOP).
- Starts a packet only when the FIFO has headroom, discards stray non-SOP beats, and keeps per-source packet and drop statistics.
- Sits directly upstream of the FIFO's data_in interface, in the same clock domain.

---
 rtl/timing_adapter_arb_32.sv | 112 +++++++++++
 1 files changed

// File: rtl/timing_adapter_arb_32.sv
// Two-source packet-level round-robin arbiter feeding the timing adapter FIFO input.
// Zero-cycle pass-through while a source owns the output; one cycle to arbitrate from IDLE.
module timing_adapter_arb_32 #(
    parameter int DATA_WIDTH  = 37,
    parameter int FILL_THRESH = 6,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            fill_level,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic [7:0]            drop_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam logic [3:0] THRESH = FILL_THRESH[3:0];

    logic [1:0]           state_q, state_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [7:0]           drop_q, drop_d;
    logic [8:0]           drop_sum;
    logic                 start_ok, req0, req1, stray0, stray1;

    assign start_ok = (fill_level < THRESH);
    assign req0     = in0_valid &&  in0_data[32];
    assign req1     = in1_valid &&  in1_data[32];
    assign stray0   = in0_valid && !in0_data[32];
    assign stray1   = in1_valid && !in1_data[32];
    assign drop_sum = {1'b0, drop_q} + 9'(stray0) + 9'(stray1);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        drop_d    = drop_q;
        out_valid = 1'b0;
        out_data  = '0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // SOP beats wait here untouched; only stray beats are consumed
                in0_ready = stray0;
                in1_ready = stray1;
                drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
                if (start_ok) begin
                    if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
                    else if (req0)    state_d = OWN0;
                    else if (req1)    state_d = OWN1;
                end
            end
            OWN0: begin
                out_valid = in0_valid;
                out_data  = in0_data;
                in0_ready = out_ready;
                if (in0_valid && out_ready && in0_data[33]) begin
                    last_d  = 1'b0;
                    cnt0_d  = cnt0_q + 1'b1;
                    state_d = (req1 && start_ok) ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                out_valid = in1_valid;
                out_data  = in1_data;
                in1_ready = out_ready;
                if (in1_valid && out_ready && in1_data[33]) begin
                    last_d  = 1'b1;
                    cnt1_d  = cnt1_q + 1'b1;
                    state_d = (req0 && start_ok) ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            drop_q  <= drop_d;
        end
    end

    assign grant    = {state_q == OWN1, state_q == OWN0};
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
    assign drop_cnt = drop_q;

endmodule
